// File: rtl/i2c_target_if.sv
// rtl/i2c_target_if.sv - bus and register-port bundle for the I2C target
//
// Signals:
//   scl, sda_in       bus clock and sensed bus data (master -> target)
//   sda_out, sda_en   target SDA drive value and drive enable (open-drain style)
//   reg_addr          register pointer (write target or read source)
//   wr_data, wr_valid received data byte and its 1-cycle strobe
//   rd_req, rd_data   1-cycle read request and the byte returned the next cycle
//   busy              target is addressed and engaged in a transfer
// Modports: slave = the target side, master = the bus/register-file side.

interface i2c_target_if;
   logic       scl;
   logic       sda_in;
   logic       sda_out;
   logic       sda_en;
   logic [7:0] reg_addr;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       rd_req;
   logic [7:0] rd_data;
   logic       busy;

   modport slave (
      input  scl, sda_in, rd_data,
      output sda_out, sda_en, reg_addr, wr_data, wr_valid, rd_req, busy
   );

   modport master (
      output scl, sda_in, rd_data,
      input  sda_out, sda_en, reg_addr, wr_data, wr_valid, rd_req, busy
   );
endinterface

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target with register pointer, byte-write strobe and read port
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    i2c_target_if.slave: scl/sda_in in, sda_out/sda_en out, register port
//          (reg_addr, wr_data, wr_valid, rd_req, rd_data) and busy
// Parameters:
//   ADDR         own 7-bit target address
//   SYNC_STAGES  synchronizer depth on scl/sda_in (>= 2)
//   DRIVE_DLY    clk cycles from detected SCL fall to asserting/changing SDA

module i2c_target #(
   parameter logic [6:0] ADDR        = 7'h50,
   parameter int          SYNC_STAGES = 2,
   parameter int          DRIVE_DLY   = 8
) (
   input logic         clk,
   input logic         rst_n,
   i2c_target_if.slave bus
);

   localparam int DLY_W = $clog2(DRIVE_DLY + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ACK_A, S_WR_BYTE, S_ACK_W, S_RD_BYTE, S_ACK_M, S_IGNORE
   } state_t;

   // Input synchronizers plus one history flop each; reset to the idle-bus level.
   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_d, sda_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
         scl_d    <= scl_sync[SYNC_STAGES-1];
         sda_d    <= sda_sync[SYNC_STAGES-1];
      end
   end

   logic       scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;
   logic [7:0] shift_in;

   assign scl_s    = scl_sync[SYNC_STAGES-1];
   assign sda_s    = sda_sync[SYNC_STAGES-1];
   assign scl_rise =  scl_s & ~scl_d;
   assign scl_fall = ~scl_s &  scl_d;
   assign start_c  =  scl_s & ~sda_s &  sda_d;
   assign stop_c   =  scl_s &  sda_s & ~sda_d;

   state_t     state;
   logic [3:0] bit_cnt;
   logic [7:0] shreg;
   logic       rw;          // R/W bit of the matched address byte
   logic       first;       // next write byte is the register pointer
   logic       data_flag;   // last write byte was data, so bump the pointer on release
   logic       ninth;       // 9th SCL rising edge of an ACK slot already seen
   logic       load;        // capture rd_data this cycle (one cycle after rd_req)
   logic       drive_pend;  // SDA assert/change waiting out DRIVE_DLY
   logic       pend_out;
   logic [DLY_W-1:0] dly_cnt;

   assign shift_in = {shreg[6:0], sda_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         bit_cnt      <= '0;
         shreg        <= '0;
         rw           <= 1'b0;
         first        <= 1'b0;
         data_flag    <= 1'b0;
         ninth        <= 1'b0;
         load         <= 1'b0;
         drive_pend   <= 1'b0;
         pend_out     <= 1'b1;
         dly_cnt      <= '0;
         bus.sda_en   <= 1'b0;
         bus.sda_out  <= 1'b1;
         bus.reg_addr <= '0;
         bus.wr_data  <= '0;
         bus.wr_valid <= 1'b0;
         bus.rd_req   <= 1'b0;
         bus.busy     <= 1'b0;
      end else begin
         bus.wr_valid <= 1'b0;
         bus.rd_req   <= 1'b0;
         load         <= bus.rd_req;
         if (load)
            shreg <= bus.rd_data;

         // Deferred drive: lands DRIVE_DLY cycles after the SCL-fall detection.
         if (drive_pend) begin
            if (dly_cnt == '0) begin
               bus.sda_en  <= 1'b1;
               bus.sda_out <= pend_out;
               drive_pend  <= 1'b0;
            end else begin
               dly_cnt <= dly_cnt - DLY_W'(1);
            end
         end

         // Bus conditions override everything below, in every state.
         if (start_c) begin
            state       <= S_ADDR;
            bit_cnt     <= '0;
            bus.sda_en  <= 1'b0;
            bus.sda_out <= 1'b1;
            drive_pend  <= 1'b0;
            bus.busy    <= 1'b0;
         end else if (stop_c) begin
            state       <= S_IDLE;
            bus.sda_en  <= 1'b0;
            bus.sda_out <= 1'b1;
            drive_pend  <= 1'b0;
            bus.busy    <= 1'b0;
         end else begin
            case (state)
               S_ADDR: if (scl_rise) begin
                  shreg   <= shift_in;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     if (shift_in[7:1] == ADDR) begin
                        bus.busy <= 1'b1;
                        rw       <= shift_in[0];
                        ninth    <= 1'b0;
                        state    <= S_ACK_A;
                     end else begin
                        state <= S_IGNORE;
                     end
                  end
               end

               S_ACK_A: begin
                  if (scl_rise) begin
                     ninth <= 1'b1;
                     if (rw)
                        bus.rd_req <= 1'b1;
                  end else if (scl_fall) begin
                     if (!ninth) begin
                        // 8th fall: schedule the ACK low.
                        drive_pend <= 1'b1;
                        pend_out   <= 1'b0;
                        dly_cnt    <= DLY_W'(DRIVE_DLY - 1);
                     end else begin
                        bus.sda_en  <= 1'b0;
                        bus.sda_out <= 1'b1;
                        bit_cnt     <= '0;
                        if (rw) begin
                           state      <= S_RD_BYTE;
                           drive_pend <= 1'b1;
                           pend_out   <= shreg[7];
                           dly_cnt    <= DLY_W'(DRIVE_DLY - 1);
                        end else begin
                           state      <= S_WR_BYTE;
                           first      <= 1'b1;
                           drive_pend <= 1'b0;
                        end
                     end
                  end
               end

               S_WR_BYTE: if (scl_rise) begin
                  shreg   <= shift_in;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     if (first) begin
                        bus.reg_addr <= shift_in;
                        first        <= 1'b0;
                        data_flag    <= 1'b0;
                     end else begin
                        bus.wr_data  <= shift_in;
                        bus.wr_valid <= 1'b1;
                        data_flag    <= 1'b1;
                     end
                     ninth <= 1'b0;
                     state <= S_ACK_W;
                  end
               end

               S_ACK_W: begin
                  if (scl_rise) begin
                     ninth <= 1'b1;
                  end else if (scl_fall) begin
                     if (!ninth) begin
                        drive_pend <= 1'b1;
                        pend_out   <= 1'b0;
                        dly_cnt    <= DLY_W'(DRIVE_DLY - 1);
                     end else begin
                        bus.sda_en  <= 1'b0;
                        bus.sda_out <= 1'b1;
                        drive_pend  <= 1'b0;
                        bit_cnt     <= '0;
                        if (data_flag)
                           bus.reg_addr <= bus.reg_addr + 8'd1;
                        state <= S_WR_BYTE;
                     end
                  end
               end

               S_RD_BYTE: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        // Hand SDA to the master for its ACK/NACK.
                        bus.sda_en  <= 1'b0;
                        bus.sda_out <= 1'b1;
                        drive_pend  <= 1'b0;
                        ninth       <= 1'b0;
                        state       <= S_ACK_M;
                     end else begin
                        // shreg[6] is the next bit; shreg[7] is already on the bus.
                        drive_pend <= 1'b1;
                        pend_out   <= shreg[6];
                        dly_cnt    <= DLY_W'(DRIVE_DLY - 1);
                        shreg      <= {shreg[6:0], 1'b0};
                     end
                  end
               end

               S_ACK_M: begin
                  if (scl_rise) begin
                     if (!sda_s) begin
                        bus.reg_addr <= bus.reg_addr + 8'd1;
                        bus.rd_req   <= 1'b1;
                        ninth        <= 1'b1;
                     end else begin
                        bus.busy <= 1'b0;
                        state    <= S_IGNORE;
                     end
                  end else if (scl_fall && ninth) begin
                     bit_cnt    <= '0;
                     state      <= S_RD_BYTE;
                     drive_pend <= 1'b1;
                     pend_out   <= shreg[7];
                     dly_cnt    <= DLY_W'(DRIVE_DLY - 1);
                  end
               end

               default: ;  // S_IDLE, S_IGNORE: only START/STOP move us on
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - self-checking bench for i2c_target (bench acts as bus master)

module tb_i2c_target;
   localparam int Q = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic m_scl = 1'b1;
   logic m_sda = 1'b1;
   logic rd_mode = 1'b1;   // 1: rd_data = addr ^ 0x5A, 0: register file contents
   int   vec = 0;
   int   errs = 0;

   always #10 clk = ~clk;

   i2c_target_if bus ();
   assign bus.scl    = m_scl;
   assign bus.sda_in = m_sda & (bus.sda_en ? bus.sda_out : 1'b1);

   i2c_target #(.ADDR(7'h50), .SYNC_STAGES(2), .DRIVE_DLY(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Register file seen by the target, plus observation queues.
   logic [7:0]  regs [256];
   logic [15:0] wr_q [$];
   logic [7:0]  rd_q [$];
   int          en_cnt = 0;
   int          busy_cnt = 0;

   always @(posedge clk) begin
      if (bus.wr_valid) regs[bus.reg_addr] <= bus.wr_data;
      if (bus.rd_req)   bus.rd_data <= rd_mode ? (bus.reg_addr ^ 8'h5A) : regs[bus.reg_addr];
   end

   always @(negedge clk) begin
      if (bus.wr_valid) wr_q.push_back({bus.reg_addr, bus.wr_data});
      if (bus.rd_req)   rd_q.push_back(bus.reg_addr);
      if (bus.sda_en)   en_cnt++;
      if (bus.busy)     busy_cnt++;
   end

   // Reference register contents, maintained from what the bench itself wrote.
   logic [7:0] model_mem [256];

   function automatic logic [15:0] wr_at(int i);
      return (i < wr_q.size()) ? wr_q[i] : 16'hDEAD;
   endfunction

   function automatic logic [7:0] rd_at(int i);
      return (i < rd_q.size()) ? rd_q[i] : 8'hEE;
   endfunction

   task automatic clk_n(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic m_start;
      clk_n(4); m_sda = 1'b1;
      clk_n(Q); m_scl = 1'b1;
      clk_n(Q); m_sda = 1'b0;
      clk_n(Q); m_scl = 1'b0;
   endtask

   task automatic m_stop;
      clk_n(4); m_sda = 1'b0;
      clk_n(Q); m_scl = 1'b1;
      clk_n(Q); m_sda = 1'b1;
      clk_n(Q);
   endtask

   task automatic m_bit(input logic b, output logic r);
      clk_n(4); m_sda = b;
      clk_n(Q); m_scl = 1'b1;
      clk_n(Q/2); r = bus.sda_in;
      clk_n(Q/2); m_scl = 1'b0;
   endtask

   task automatic m_wbyte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) m_bit(b[i], r);
      m_bit(1'b1, r);
      ack = ~r;
   endtask

   task automatic m_rbyte(input logic ack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         m_bit(1'b1, r);
         d[i] = r;
      end
      m_bit(~ack, r);
   endtask

   task automatic test_reset;
      vec++; if (bus.sda_en !== 1'b0)     begin errs++; $display("FAIL reset_sda_en: got %b want 0", bus.sda_en); end
      vec++; if (bus.sda_out !== 1'b1)    begin errs++; $display("FAIL reset_sda_out: got %b want 1", bus.sda_out); end
      vec++; if (bus.wr_valid !== 1'b0)   begin errs++; $display("FAIL reset_wr_valid: got %b want 0", bus.wr_valid); end
      vec++; if (bus.rd_req !== 1'b0)     begin errs++; $display("FAIL reset_rd_req: got %b want 0", bus.rd_req); end
      vec++; if (bus.busy !== 1'b0)       begin errs++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      vec++; if (bus.reg_addr !== 8'h00)  begin errs++; $display("FAIL reset_reg_addr: got %h want 00", bus.reg_addr); end
   endtask

   task automatic test_write;
      int wb = wr_q.size();
      logic a0, a1, a2;
      m_start;
      m_wbyte(8'hA0, a0); m_wbyte(8'h10, a1); m_wbyte(8'hA5, a2);
      vec++; if ({a0, a1, a2} !== 3'b111) begin errs++; $display("FAIL write_acks: got %b want 111", {a0, a1, a2}); end
      vec++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL write_busy: got %b want 1", bus.busy); end
      m_stop;
      vec++; if (wr_q.size() - wb != 1) begin errs++; $display("FAIL write_count: got %0d want 1", wr_q.size() - wb); end
      vec++; if (wr_at(wb) !== 16'h10A5) begin errs++; $display("FAIL write_entry: got %h want 10a5", wr_at(wb)); end
      vec++; if (bus.reg_addr !== 8'h11) begin errs++; $display("FAIL write_ptr: got %h want 11", bus.reg_addr); end
      vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL write_busy_stop: got %b want 0", bus.busy); end
   endtask

   task automatic test_read;
      int wb = wr_q.size();
      int rb = rd_q.size();
      logic a0, a1, a2;
      logic [7:0] d;
      rd_mode = 1'b1;
      m_start; m_wbyte(8'hA0, a0); m_wbyte(8'h00, a1);
      m_start; m_wbyte(8'hA1, a2);
      vec++; if ({a0, a1, a2} !== 3'b111) begin errs++; $display("FAIL read_acks: got %b want 111", {a0, a1, a2}); end
      for (int k = 0; k < 7; k++) begin
         m_rbyte(k < 6, d);
         vec++; if (d !== (8'(k) ^ 8'h5A)) begin errs++; $display("FAIL read_byte%0d: got %h want %h", k, d, 8'(k) ^ 8'h5A); end
      end
      clk_n(2);
      vec++; if (bus.sda_en !== 1'b0) begin errs++; $display("FAIL read_nack_release: got %b want 0", bus.sda_en); end
      vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL read_nack_busy: got %b want 0", bus.busy); end
      vec++; if (bus.reg_addr !== 8'h06) begin errs++; $display("FAIL read_ptr: got %h want 06", bus.reg_addr); end
      m_stop;
      vec++; if (rd_q.size() - rb != 7) begin errs++; $display("FAIL read_req_count: got %0d want 7", rd_q.size() - rb); end
      for (int k = 0; k < 7; k++) begin
         vec++; if (rd_at(rb + k) !== 8'(k)) begin errs++; $display("FAIL read_req_addr%0d: got %h want %h", k, rd_at(rb + k), 8'(k)); end
      end
      vec++; if (wr_q.size() != wb) begin errs++; $display("FAIL read_no_write: got %0d want 0", wr_q.size() - wb); end
   endtask

   task automatic test_mismatch;
      for (int it = 0; it < 3; it++) begin
         int wb = wr_q.size();
         int rb = rd_q.size();
         int e0 = en_cnt;
         int b0 = busy_cnt;
         logic [6:0] a;
         logic ack0, ack1;
         do a = 7'($urandom_range(0, 127)); while (a == 7'h50);
         m_start;
         m_wbyte({a, 1'($urandom_range(0, 1))}, ack0);
         m_wbyte(8'($urandom), ack1);
         m_stop;
         vec++; if ({ack0, ack1} !== 2'b00) begin errs++; $display("FAIL mismatch_ack: got %b want 00 (addr %h)", {ack0, ack1}, a); end
         vec++; if (en_cnt != e0) begin errs++; $display("FAIL mismatch_sda_en: got %0d driven cycles want 0", en_cnt - e0); end
         vec++; if (busy_cnt != b0) begin errs++; $display("FAIL mismatch_busy: got %0d busy cycles want 0", busy_cnt - b0); end
         vec++; if (wr_q.size() != wb || rd_q.size() != rb) begin errs++; $display("FAIL mismatch_port: got %0d wr %0d rd want 0 0", wr_q.size() - wb, rd_q.size() - rb); end
      end
   endtask

   task automatic test_stop_mid;
      int wb = wr_q.size();
      logic [7:0] ptr = 8'($urandom);
      logic [7:0] ptr2 = 8'($urandom);
      logic [7:0] dat = 8'($urandom);
      logic a0, a1, a2, r;
      m_start; m_wbyte(8'hA0, a0); m_wbyte(ptr, a1);
      for (int i = 0; i < 4; i++) m_bit(1'($urandom_range(0, 1)), r);
      m_stop;
      vec++; if (wr_q.size() != wb) begin errs++; $display("FAIL stopmid_no_write: got %0d want 0", wr_q.size() - wb); end
      vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL stopmid_busy: got %b want 0", bus.busy); end
      vec++; if (bus.reg_addr !== ptr) begin errs++; $display("FAIL stopmid_ptr: got %h want %h", bus.reg_addr, ptr); end
      m_start; m_wbyte(8'hA0, a0); m_wbyte(ptr2, a1); m_wbyte(dat, a2); m_stop;
      vec++; if ({a0, a1, a2} !== 3'b111) begin errs++; $display("FAIL stopmid_next_acks: got %b want 111", {a0, a1, a2}); end
      vec++; if (wr_at(wb) !== {ptr2, dat}) begin errs++; $display("FAIL stopmid_next_write: got %h want %h", wr_at(wb), {ptr2, dat}); end
   endtask

   task automatic test_reset_mid;
      int n = 0;
      logic a0;
      logic [7:0] d;
      rd_mode = 1'b1;
      m_start; m_wbyte(8'hA1, a0);
      while (!bus.sda_en && n < 40) begin clk_n(1); n++; end
      vec++; if (bus.sda_en !== 1'b1) begin errs++; $display("FAIL rstmid_driving: got %b want 1 within 40 clk", bus.sda_en); end
      @(posedge clk); #2 rst_n = 1'b0; #1;
      vec++; if (bus.sda_en !== 1'b0) begin errs++; $display("FAIL rstmid_async_release: got %b want 0", bus.sda_en); end
      m_scl = 1'b1; m_sda = 1'b1;
      clk_n(3);
      vec++; if ({bus.sda_en, bus.sda_out, bus.wr_valid, bus.rd_req, bus.busy} !== 5'b01000)
         begin errs++; $display("FAIL rstmid_outputs: got %b want 01000", {bus.sda_en, bus.sda_out, bus.wr_valid, bus.rd_req, bus.busy}); end
      vec++; if (bus.reg_addr !== 8'h00) begin errs++; $display("FAIL rstmid_ptr: got %h want 00", bus.reg_addr); end
      rst_n = 1'b1;
      clk_n(4);
      m_start; m_wbyte(8'hA1, a0);
      vec++; if (a0 !== 1'b1) begin errs++; $display("FAIL rstmid_readdr_ack: got %b want 1", a0); end
      m_rbyte(1'b0, d);
      m_stop;
      vec++; if (d !== 8'h5A) begin errs++; $display("FAIL rstmid_read: got %h want 5a", d); end
   endtask

   task automatic test_wrap;
      int wb = wr_q.size();
      logic a0, a1, a2, a3;
      m_start; m_wbyte(8'hA0, a0); m_wbyte(8'hFF, a1); m_wbyte(8'h11, a2); m_wbyte(8'h22, a3); m_stop;
      vec++; if ({a0, a1, a2, a3} !== 4'b1111) begin errs++; $display("FAIL wrap_acks: got %b want 1111", {a0, a1, a2, a3}); end
      vec++; if (wr_at(wb) !== 16'hFF11) begin errs++; $display("FAIL wrap_first: got %h want ff11", wr_at(wb)); end
      vec++; if (wr_at(wb + 1) !== 16'h0022) begin errs++; $display("FAIL wrap_second: got %h want 0022", wr_at(wb + 1)); end
      vec++; if (bus.reg_addr !== 8'h01) begin errs++; $display("FAIL wrap_ptr: got %h want 01", bus.reg_addr); end
   endtask

   task automatic test_random;
      rd_mode = 1'b0;
      for (int it = 0; it < 4; it++) begin
         logic [7:0] ptr = 8'($urandom);
         int         nb = $urandom_range(1, 4);
         int         wb = wr_q.size();
         int         rb = rd_q.size();
         logic [7:0] dat;
         logic [7:0] d;
         logic       a;
         m_start; m_wbyte(8'hA0, a); m_wbyte(ptr, a);
         for (int i = 0; i < nb; i++) begin
            dat = 8'($urandom);
            model_mem[8'(ptr + 8'(i))] = dat;
            m_wbyte(dat, a);
         end
         m_stop;
         for (int i = 0; i < nb; i++) begin
            vec++; if (wr_at(wb + i) !== {8'(ptr + 8'(i)), model_mem[8'(ptr + 8'(i))]})
               begin errs++; $display("FAIL rand_write%0d_%0d: got %h want %h", it, i, wr_at(wb + i), {8'(ptr + 8'(i)), model_mem[8'(ptr + 8'(i))]}); end
         end
         m_start; m_wbyte(8'hA0, a); m_wbyte(ptr, a);
         m_start; m_wbyte(8'hA1, a);
         for (int i = 0; i < nb; i++) begin
            m_rbyte(i < nb - 1, d);
            vec++; if (d !== model_mem[8'(ptr + 8'(i))]) begin errs++; $display("FAIL rand_read%0d_%0d: got %h want %h", it, i, d, model_mem[8'(ptr + 8'(i))]); end
            vec++; if (rd_at(rb + i) !== 8'(ptr + 8'(i))) begin errs++; $display("FAIL rand_req%0d_%0d: got %h want %h", it, i, rd_at(rb + i), 8'(ptr + 8'(i))); end
         end
         m_stop;
      end
   endtask

   initial begin
      clk_n(5);
      rst_n = 1'b1;
      clk_n(5);
      test_reset;
      test_write;
      test_read;
      test_mismatch;
      test_stop_mid;
      test_reset_mid;
      test_wrap;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
